// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M multiply/divide sequencer: M-op encoding, FSM states,
// iteration count and operand signedness decode.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldivOp_;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } muldivState_;

  localparam int MULDIV_ITERATIONS = 32;

  // second = 0 asks about rs1, second = 1 about rs2
  function automatic logic isSignedOp(input muldivOp_ op, input logic second);
    case (op)
      MD_MULH, MD_DIV, MD_REM: isSignedOp = 1'b1;
      MD_MULHSU:               isSignedOp = ~second;
      default:                 isSignedOp = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit beside the execute ALU: one shared 33-bit
// adder drives a shift-add multiply or restoring divide, stalling execute meanwhile.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int ITERATIONS = MULDIV_ITERATIONS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic        flush,
  input  logic        advance,
  output logic        stallRequest,
  output logic        done,
  output logic [31:0] result
);

  muldivState_ state, next_state;
  muldivOp_    op_in, op_latched;
  logic [5:0]  counter;
  logic [31:0] acc_hi, acc_lo, divisor;
  logic        negate;

  logic        neg1, neg2, start_negate, div_zero, overflow;
  logic [31:0] abs1, abs2, special_value;
  logic        accept, fast, finish, last, is_div;

  logic [32:0] add_a, add_b;
  logic        add_cin;
  logic [33:0] add_sum;
  logic [31:0] hi_next, lo_next, quot_fix, rem_fix, final_value;
  logic [63:0] product, product_fix;

  assign op_in  = muldivOp_'(op);
  assign is_div = (op_latched >= MD_DIV);
  assign last   = (counter == 6'(ITERATIONS - 1));

  // Operand conditioning and divide special cases decided in the IDLE cycle
  always_comb begin
    neg1 = isSignedOp(op_in, 1'b0) & operand1[31];
    neg2 = isSignedOp(op_in, 1'b1) & operand2[31];
    abs1 = neg1 ? (~operand1 + 32'd1) : operand1;
    abs2 = neg2 ? (~operand2 + 32'd1) : operand2;
    div_zero = (op_in >= MD_DIV) && (operand2 == 32'd0);
    overflow = ((op_in == MD_DIV) || (op_in == MD_REM)) &&
               (operand1 == 32'h8000_0000) && (operand2 == 32'hFFFF_FFFF);
    if ((op_in == MD_REM) || (op_in == MD_REMU)) begin
      start_negate = neg1;
    end else begin
      start_negate = neg1 ^ neg2;
    end
    if (div_zero) begin
      special_value = ((op_in == MD_REM) || (op_in == MD_REMU)) ? operand1 : 32'hFFFF_FFFF;
    end else if (overflow) begin
      special_value = (op_in == MD_REM) ? 32'd0 : 32'h8000_0000;
    end else begin
      special_value = 32'd0;
    end
  end

  // Shared adder: adds the multiplicand for multiply, subtracts the divisor (carry = no borrow) for divide
  always_comb begin
    if (is_div) begin
      add_a   = {acc_hi, acc_lo[31]};
      add_b   = ~{1'b0, divisor};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, acc_hi};
      add_b   = acc_lo[0] ? {1'b0, divisor} : 33'd0;
      add_cin = 1'b0;
    end
  end

  assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {33'd0, add_cin};

  // One iteration step plus sign fix and word selection for the final step
  always_comb begin
    if (is_div) begin
      hi_next = add_sum[33] ? add_sum[31:0] : add_a[31:0];
      lo_next = {acc_lo[30:0], add_sum[33]};
    end else begin
      hi_next = add_sum[32:1];
      lo_next = {add_sum[0], acc_lo[31:1]};
    end
    product     = {hi_next, lo_next};
    product_fix = negate ? (~product + 64'd1) : product;
    quot_fix    = negate ? (~lo_next + 32'd1) : lo_next;
    rem_fix     = negate ? (~hi_next + 32'd1) : hi_next;
    case (op_latched)
      MD_MUL:                       final_value = product_fix[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU: final_value = product_fix[63:32];
      MD_DIV, MD_DIVU:              final_value = quot_fix;
      default:                      final_value = rem_fix;
    endcase
  end

  // Next-state logic; flush wins in every state
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    fast       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          accept = 1'b1;
          if (div_zero || overflow) begin
            fast       = 1'b1;
            next_state = DONE;
          end else begin
            next_state = RUN;
          end
        end else begin
          next_state = IDLE;
        end
      end
      RUN: begin
        if (flush) begin
          next_state = IDLE;
        end else if (last) begin
          finish     = 1'b1;
          next_state = DONE;
        end else begin
          next_state = RUN;
        end
      end
      DONE: begin
        if (flush || advance) begin
          next_state = IDLE;
        end else begin
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign stallRequest = ((state == IDLE) && start && !flush) || (state == RUN);
  assign done         = (state == DONE);

  // State, datapath and result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      op_latched <= MD_MUL;
      counter    <= 6'd0;
      acc_hi     <= 32'd0;
      acc_lo     <= 32'd0;
      divisor    <= 32'd0;
      negate     <= 1'b0;
      result     <= 32'd0;
    end else begin
      state <= next_state;
      if (accept && !fast) begin
        op_latched <= op_in;
        acc_hi     <= 32'd0;
        acc_lo     <= abs1;
        divisor    <= abs2;
        negate     <= start_negate;
        counter    <= 6'd0;
      end else if (state == RUN) begin
        acc_hi  <= hi_next;
        acc_lo  <= lo_next;
        counter <= counter + 6'd1;
      end
      if (fast) begin
        result <= special_value;
      end else if (finish) begin
        result <= final_value;
      end
    end
  end

endmodule
